// File: rtl/alu_md_unit_if.sv
// alu_md_unit_if: operand/op-select bus into the execute-stage ALU and
// the result, flag and HI/LO bus coming back out of it.
interface alu_md_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALUcont;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             md_start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output ALUcont, A, B, md_start,
        input  result, zero, overflow, busy, md_done, hi, lo
    );

    modport slave (
        input  ALUcont, A, B, md_start,
        output result, zero, overflow, busy, md_done, hi, lo
    );
endinterface

// File: rtl/alu_md_unit.sv
// alu_md_unit: single-cycle logic/arith/shift ALU plus a bit-serial
// unsigned multiply/divide engine that writes the HI/LO registers.
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_md_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] qr_nxt;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   ddiff;
    logic             dge;
    logic             start_ok;
    logic             busy_i;
    logic             last;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign sh     = bus.B[SHW-1:0];
    assign sum    = bus.A + bus.B;
    assign diff   = bus.A - bus.B;
    assign busy_i = (state == MUL) || (state == DIV);
    assign last   = (cnt == CNT_ONE);
    assign start_ok = ((state == IDLE) || (state == DONE))
                    && bus.md_start
                    && (bus.ALUcont[3:1] == 3'b111);

    // Combinational operation select; MFHI/MFLO read committed HI/LO only.
    always_comb begin
        res = '0;
        case (bus.ALUcont)
            4'b0000: res = bus.A & bus.B;
            4'b0001: res = bus.A | bus.B;
            4'b0010: res = sum;
            4'b0011: res = bus.A ^ bus.B;
            4'b0100: res = bus.A & ~bus.B;
            4'b0101: res = bus.A | ~bus.B;
            4'b0110: res = diff;
            4'b0111: res = {{(WIDTH-1){1'b0}},
                            ($signed(bus.A) < $signed(bus.B))};
            4'b1000: res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'b1001: res = bus.A << sh;
            4'b1010: res = bus.A >> sh;
            4'b1011: res = $signed(bus.A) >>> sh;
            4'b1100: res = hi_q;
            4'b1101: res = lo_q;
            default: res = '0;
        endcase
    end

    // Signed overflow flag, meaningful for ADD and SUB only.
    always_comb begin
        ovf = 1'b0;
        if (bus.ALUcont == 4'b0010)
            ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
               && (sum[WIDTH-1] != bus.A[WIDTH-1]);
        else if (bus.ALUcont == 4'b0110)
            ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1])
               && (diff[WIDTH-1] != bus.A[WIDTH-1]);
    end

    // One step of shift-add multiply or restoring divide.
    always_comb begin
        msum    = {1'b0, acc} + (qr[0] ? {1'b0, opd} : '0);
        dshift  = {acc, qr[WIDTH-1]};
        dge     = (dshift >= {1'b0, opd});
        ddiff   = dshift - {1'b0, opd};
        acc_nxt = acc;
        qr_nxt  = qr;
        if (state == MUL) begin
            acc_nxt = msum[WIDTH:1];
            qr_nxt  = {msum[0], qr[WIDTH-1:1]};
        end else if (state == DIV) begin
            acc_nxt = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
            qr_nxt  = {qr[WIDTH-2:0], dge};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: accept starts when idle or finishing, run WIDTH steps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nxt = bus.ALUcont[0] ? DIV : MUL;
                else          state_nxt = IDLE;
            end
            MUL, DIV: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers; HI/LO written only on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            opd  <= '0;
            acc  <= '0;
            qr   <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (start_ok) begin
            cnt <= CNT_INIT;
            acc <= '0;
            if (bus.ALUcont[0]) begin
                qr  <= bus.A;
                opd <= bus.B;
            end else begin
                qr  <= bus.B;
                opd <= bus.A;
            end
        end else if (busy_i) begin
            cnt <= cnt - CNT_ONE;
            acc <= acc_nxt;
            qr  <= qr_nxt;
            if (last) begin
                hi_q <= acc_nxt;
                lo_q <= qr_nxt;
            end
        end
    end

    assign bus.result   = res;
    assign bus.zero     = (res == '0);
    assign bus.overflow = ovf;
    assign bus.busy     = busy_i;
    assign bus.md_done  = (state == DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: random and directed stimulus against an arithmetic
// reference model, plus literal expectations from worked examples.
module tb_alu_md_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    alu_md_unit_if #(.WIDTH(32)) bus ();

    alu_md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          m_cnt;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done;

    function automatic logic [63:0] md_ref(logic [3:0] op,
                                           logic [31:0] a, logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        if (op == 4'b1110) return ua * ub;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    function automatic logic [31:0] res_ref(logic [3:0] op,
        logic [31:0] a, logic [31:0] b, logic [31:0] h, logic [31:0] l);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        int sh = int'(b % 32);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'(ua + ub);
            4'd3:  return a ^ b;
            4'd4:  return a & ~b;
            4'd5:  return a | ~b;
            4'd6:  return 32'(ua - ub);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd9:  return 32'(ua << sh);
            4'd10: return 32'(ua >> sh);
            4'd11: return 32'(sa >>> sh);
            4'd12: return h;
            4'd13: return l;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ovf_ref(logic [3:0] op,
                                     logic [31:0] a, logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s;
        if (op == 4'd2) s = sa + sb;
        else if (op == 4'd6) s = sa - sb;
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Model: a start seen while idle completes WIDTH edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (bus.md_start && bus.ALUcont >= 4'd14) begin
                m_cnt <= 32;
                {p_hi, p_lo} <= md_ref(bus.ALUcont, bus.A, bus.B);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] er;
            er = res_ref(bus.ALUcont, bus.A, bus.B, m_hi, m_lo);
            check("result", bus.result, er);
            check("zero", 32'(bus.zero), 32'(er == 0));
            check("overflow", 32'(bus.overflow),
                  32'(ovf_ref(bus.ALUcont, bus.A, bus.B)));
            check("busy", 32'(bus.busy), 32'(m_cnt != 0));
            check("md_done", 32'(bus.md_done), 32'(m_done));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        @(posedge clk);
        #1;
        bus.ALUcont  = op;
        bus.A        = a;
        bus.B        = b;
        bus.md_start = 1'b0;
        #1;
    endtask

    // Issue a MULTU/DIVU now; return busy cycles and whether done seen.
    task automatic run_md(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                          bit disturb, logic [31:0] prev_lo,
                          output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        bus.ALUcont  = op;
        bus.A        = a;
        bus.B        = b;
        bus.md_start = 1'b1;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
        bus.ALUcont  = 4'b1100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.md_done) begin
                seen = 1'b1;
                #2;
                break;
            end
            if (disturb && i == 5) begin
                #2;
                bus.ALUcont  = 4'b1110;
                bus.md_start = 1'b1;
                bus.A        = $urandom;
                bus.B        = $urandom;
            end
            if (disturb && i == 6) begin
                #2;
                bus.md_start = 1'b0;
                bus.ALUcont  = 4'b1101;
                #1;
                check("mflo_busy", bus.result, prev_lo);
            end
        end
        if (!seen) check("md_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bn;
        bit sd;
        int dn;
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.ALUcont  = 4'd0;
        bus.A        = '0;
        bus.B        = '0;
        bus.md_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.md_done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;

        drive(4'b0010, 32'h7FFF_FFFF, 32'd1);
        check("add_res", bus.result, 32'h8000_0000);
        check("add_ovf", 32'(bus.overflow), 32'd1);
        check("add_zero", 32'(bus.zero), 32'd0);
        drive(4'b0110, 32'd5, 32'd5);
        check("sub_res", bus.result, 32'd0);
        check("sub_zero", 32'(bus.zero), 32'd1);
        drive(4'b0011, 32'hF0F0, 32'hFFFF);
        check("xor_res", bus.result, 32'h0F0F);
        drive(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt", bus.result, 32'd1);
        drive(4'b1000, 32'hFFFF_FFFF, 32'd1);
        check("sltu", bus.result, 32'd0);
        drive(4'b1011, 32'h8000_0000, 32'd4);
        check("sra", bus.result, 32'hF800_0000);
        drive(4'b1010, 32'h8000_0000, 32'd4);
        check("srl", bus.result, 32'h0800_0000);
        drive(4'b1001, 32'h8000_0000, 32'd4);
        check("sll", bus.result, 32'd0);
        drive(4'b1010, 32'h8000_0000, 32'd36);
        check("srl_b36", bus.result, 32'h0800_0000);

        drive(4'b0000, 32'd0, 32'd0);
        run_md(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, bn, sd);
        check("mul_busy_n", 32'(bn), 32'd32);
        check("mul_hi", bus.hi, 32'hFFFF_FFFE);
        check("mul_lo", bus.lo, 32'h0000_0001);
        drive(4'b1100, 32'd0, 32'd0);
        check("mfhi", bus.result, 32'hFFFF_FFFE);
        drive(4'b1101, 32'd0, 32'd0);
        check("mflo", bus.result, 32'h0000_0001);

        run_md(4'b1111, 32'd100, 32'd7, 1'b1, 32'd1, bn, sd);
        check("div_busy_n", 32'(bn), 32'd32);
        check("div_lo", bus.lo, 32'd14);
        check("div_hi", bus.hi, 32'd2);
        run_md(4'b1111, 32'h1234, 32'd0, 1'b0, 32'd0, bn, sd);
        check("div0_lo", bus.lo, 32'hFFFF_FFFF);
        check("div0_hi", bus.hi, 32'h1234);
        run_md(4'b1110, 32'd3, 32'd5, 1'b0, 32'd0, bn, sd);
        check("b2b_busy_n", 32'(bn), 32'd32);
        check("b2b_lo", bus.lo, 32'd15);
        check("b2b_hi", bus.hi, 32'd0);

        bus.ALUcont  = 4'b1111;
        bus.A        = 32'd1000;
        bus.B        = 32'd3;
        bus.md_start = 1'b1;
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.md_done), 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.md_done) dn++;
        end
        check("no_late_done", 32'(dn), 32'd0);
        #2;
        run_md(4'b1111, 32'd100, 32'd7, 1'b0, 32'd0, bn, sd);
        check("post_rst_lo", bus.lo, 32'd14);
        check("post_rst_hi", bus.hi, 32'd2);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.ALUcont  = 4'($urandom_range(0, 15));
            bus.A        = pick();
            bus.B        = pick();
            bus.md_start = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #1;
        bus.md_start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
